// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// The fetch address check is compiled in only when FETCH_EXC_EN is defined.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE      = 32'h0000_3000;
    localparam logic [31:0] IM_END       = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE     = 5'd0;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    // A fetch faults when it is misaligned or falls outside instruction memory.
    function automatic logic pc_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset to RESET_VAL, loads d_i when en_i is high.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register plus the IF/ID pipeline register.
// Define FETCH_EXC_EN to add the fetch address check and the ID_o_ExcCode port.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_i_nPC,
    input  logic [31:0] IF_i_Instr,
    input  logic        IF_i_Stall,
    input  logic        IF_i_Flush,
    output logic [31:0] IF_o_PC,
    output logic [31:0] ID_o_Instr,
    output logic [31:0] ID_o_PC,
    output logic [31:0] ID_o_PC8,
`ifdef FETCH_EXC_EN
    output logic [4:0]  ID_o_ExcCode,
`endif
    output logic        ID_o_Valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pc8_q,   pc8_d;
    logic        valid_q, valid_d;
    logic [31:0] load_instr;

    pc_reg #(
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~IF_i_Stall),
        .d_i   (IF_i_nPC),
        .q_o   (IF_o_PC)
    );

`ifdef FETCH_EXC_EN
    logic [4:0] exc_q, exc_d;
    logic       fetch_fault;
    logic [4:0] load_exc;

    // A faulting fetch still travels down the pipe as a valid nop carrying the exception.
    assign fetch_fault = pc_fault(IF_o_PC);
    assign load_instr  = fetch_fault ? 32'h0 : IF_i_Instr;
    assign load_exc    = fetch_fault ? EXC_ADEL : EXC_NONE;

    always_comb begin
        exc_d = exc_q;
        if (IF_i_Flush) begin
            exc_d = EXC_NONE;
        end else if (!IF_i_Stall) begin
            exc_d = load_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= EXC_NONE;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign ID_o_ExcCode = exc_q;
`else
    assign load_instr = IF_i_Instr;
`endif

    // Flush wins over stall: the PC holds but IF/ID still becomes a bubble.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (IF_i_Flush) begin
            instr_d = 32'h0;
            pc_d    = 32'h0;
            pc8_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!IF_i_Stall) begin
            instr_d = load_instr;
            pc_d    = IF_o_PC;
            pc8_d   = IF_o_PC + 32'd8;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            pc8_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
        end
    end

    assign ID_o_Instr = instr_q;
    assign ID_o_PC    = pc_q;
    assign ID_o_PC8   = pc8_q;
    assign ID_o_Valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes the expected IF/ID contents
// into a queue per step; each entry is popped and compared after the clock edge.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic [4:0]  exc;
    } id_t;

    logic        clk;
    logic        reset;
    logic [31:0] IF_i_nPC;
    logic [31:0] IF_i_Instr;
    logic        IF_i_Stall;
    logic        IF_i_Flush;
    logic [31:0] IF_o_PC;
    logic [31:0] ID_o_Instr;
    logic [31:0] ID_o_PC;
    logic [31:0] ID_o_PC8;
    logic        ID_o_Valid;
`ifdef FETCH_EXC_EN
    logic [4:0]  ID_o_ExcCode;
`endif

    logic        br;
    logic [31:0] tgt;

    int          n_vec;
    int          n_err;
    logic [31:0] m_pc;
    id_t         m_id;
    id_t         exp_q[$];

    fetch_stage #(
        .PC_RESET (RST_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .IF_i_nPC     (IF_i_nPC),
        .IF_i_Instr   (IF_i_Instr),
        .IF_i_Stall   (IF_i_Stall),
        .IF_i_Flush   (IF_i_Flush),
        .IF_o_PC      (IF_o_PC),
        .ID_o_Instr   (ID_o_Instr),
        .ID_o_PC      (ID_o_PC),
        .ID_o_PC8     (ID_o_PC8),
`ifdef FETCH_EXC_EN
        .ID_o_ExcCode (ID_o_ExcCode),
`endif
        .ID_o_Valid   (ID_o_Valid)
    );

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory and next-PC logic seen by the stage.
    always_comb IF_i_Instr = im_word(IF_o_PC);
    always_comb IF_i_nPC   = br ? tgt : IF_o_PC + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic id_t model_load(input logic [31:0] pc);
        id_t r;
        r.instr = im_word(pc);
        r.pc    = pc;
        r.pc8   = pc + 32'd8;
        r.valid = 1'b1;
        r.exc   = 5'd0;
`ifdef FETCH_EXC_EN
        if (pc[1:0] != 2'b00 || pc < 32'h0000_3000 || pc > 32'h0000_6FFC) begin
            r.instr = 32'h0;
            r.exc   = 5'd4;
        end
`endif
        return r;
    endfunction

    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] t);
        logic [31:0] npc;
        id_t         nid;
        id_t         e;
        @(negedge clk);
        reset      = r;
        IF_i_Stall = s;
        IF_i_Flush = f;
        br         = b;
        tgt        = t;
        npc = b ? t : m_pc + 32'd4;
        if (r) begin
            nid  = '0;
            m_pc = RST_PC;
        end else if (f) begin
            nid  = '0;
            m_pc = s ? m_pc : npc;
        end else if (s) begin
            nid  = m_id;
        end else begin
            nid  = model_load(m_pc);
            m_pc = npc;
        end
        m_id = nid;
        exp_q.push_back(nid);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".IF_PC"},   IF_o_PC,    m_pc);
        check({tag, ".ID_Instr"}, ID_o_Instr, e.instr);
        check({tag, ".ID_PC"},   ID_o_PC,    e.pc);
        check({tag, ".ID_PC8"},  ID_o_PC8,   e.pc8);
        check({tag, ".ID_Valid"}, {31'h0, ID_o_Valid}, {31'h0, e.valid});
`ifdef FETCH_EXC_EN
        check({tag, ".ID_Exc"},  {27'h0, ID_o_ExcCode}, {27'h0, e.exc});
`endif
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_pc       = RST_PC;
        m_id       = '0;
        reset      = 1'b1;
        IF_i_Stall = 1'b0;
        IF_i_Flush = 1'b0;
        br         = 1'b0;
        tgt        = 32'h0;

        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 0, 0);
        check("at_3010", IF_o_PC, 32'h0000_3010);
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0, 0);
        step("resume", 0, 0, 0, 0, 0);
        check("at_3014", IF_o_PC, 32'h0000_3014);
        for (int i = 0; i < 3; i++) step("run2", 0, 0, 0, 0, 0);
        step("flush", 0, 0, 1, 0, 0);
        step("after_flush", 0, 0, 0, 0, 0);
        step("flush_stall", 0, 1, 1, 0, 0);
        step("refetch", 0, 0, 0, 0, 0);
        step("branch", 0, 0, 0, 1, 32'h3000_1000);
        step("at_tgt", 0, 0, 0, 0, 0);
        step("stall_pre", 0, 1, 0, 0, 0);
        step("rst_stall", 1, 1, 0, 0, 0);
        step("run3", 0, 0, 0, 0, 0);
        step("br_mis", 0, 0, 0, 1, 32'h0000_3002);
        step("ld_mis", 0, 0, 0, 0, 0);
        step("br_7000", 0, 0, 0, 1, 32'h0000_7000);
        step("ld_7000", 0, 0, 0, 0, 0);
        step("br_6ffc", 0, 0, 0, 1, 32'h0000_6FFC);
        step("ld_6ffc", 0, 0, 0, 0, 0);
        step("br_wrap", 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("ld_wrap", 0, 0, 0, 0, 0);
        check("wrap_pc8", ID_o_PC8, 32'h0000_0004);
        step("run4", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the P6 pipeline. Holds the program counter, drives it to instruction memory and to the next-PC logic, and captures `nPC` every cycle unless stalled. Registers the fetched instruction with its PC and PC+8 (delay-slot link address) into the IF/ID pipeline register, with stall and flush control from the hazard unit. It sits between the next-PC combinational block (upstream: supplies `nPC`) and the decode stage (downstream: consumes IF/ID).

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IF_i_nPC`  in  32  next PC from next-PC logic. Only valid as a combinational function of `IF_o_PC` and decode-stage state.
- `IF_i_Instr`  in  32  instruction word read combinationally from IM at `IF_o_PC`.
- `IF_i_Stall`  in  1  hazard stall: hold PC and IF/ID.
- `IF_i_Flush`  in  1  load a bubble into IF/ID.
- `IF_o_PC`  out  32  current PC, to IM address and to next-PC logic.
- `ID_o_Instr`  out  32  registered instruction.
- `ID_o_PC`  out  32  registered PC of that instruction.
- `ID_o_PC8`  out  32  registered `ID_o_PC + 8`.
- `ID_o_Valid`  out  1  1 = real instruction, 0 = bubble.
- `ID_o_ExcCode`  out  5  fetch exception code. Present only with `FETCH_EXC_EN`.

## Operation
- PC register, updated each rising edge:
  - `reset` → `PC_RESET`.
  - else if `IF_i_Stall` → hold.
  - else → `IF_i_nPC`.
- IF/ID register, updated each rising edge, priority reset > flush > stall > load:
  - reset: Instr=0, PC=0, PC8=0, Valid=0, ExcCode=0.
  - flush: same values as reset, regardless of stall.
  - stall (no flush): hold all fields.
  - load: Instr=`IF_i_Instr`, PC=`IF_o_PC`, PC8=`IF_o_PC`+8, Valid=1, ExcCode from the check below.
- Flush and stall together: PC holds and IF/ID becomes a bubble. The held PC is fetched again on the next non-stalled edge.
- All additions are modulo 2^32; wrap at 32'hFFFF_FFFC is not trapped (PC8 wraps silently).
- No handshake beyond stall. IM is assumed to return `IF_i_Instr` in the same cycle.

## Timing
- `IF_o_PC` is a register output. The path `IF_o_PC` → next-PC → `IF_i_nPC` → PC register is the only combinational loop-free path and must close in one cycle.
- Fetch-to-decode latency: 1 cycle. The instruction at `IF_o_PC` in cycle n appears on `ID_o_*` in cycle n+1.
- After reset is released: `IF_o_PC`=`PC_RESET` in the first cycle, and `ID_o_Valid`=0 until the first load edge.
- Reset asserted mid-stream overrides stall and flush in the same edge.

## Configuration
- `FETCH_EXC_EN` defined:
  - Adds `ID_o_ExcCode`.
  - On load, if `IF_o_PC[1:0]`≠0 or `IF_o_PC` is outside [`IM_BASE`, `IM_END`], then ExcCode=`EXC_ADEL` (5'd4) and Instr=32'h0 (nop). Valid stays 1 and PC is recorded unchanged.
  - Otherwise ExcCode=`EXC_NONE` (5'd0).
- `FETCH_EXC_EN` undefined:
  - No check and no `ID_o_ExcCode` port.
  - `IF_i_Instr` is passed through unconditionally.

## Structure
- Shared macro/constant file holds: `PC_RESET` default, `IM_BASE`=32'h0000_3000, `IM_END`=32'h0000_6FFC, `EXC_NONE`, `EXC_ADEL`.
- One sub-module: `pc_reg`, the PC register with reset and enable. `fetch_stage` instantiates it and implements the IF/ID register and the exception check inline.

## Test plan
- Reset for 2 cycles, then `IF_i_nPC`=`IF_o_PC`+4 → `IF_o_PC` sequence 0x3000, 0x3004, 0x3008. `ID_o_Valid`=0 in the first cycle after reset, then 1 with `ID_o_PC`=0x3000 and `ID_o_PC8`=0x3008.
- Stall held 3 cycles at PC 0x3010 → `IF_o_PC` and all `ID_o_*` unchanged for 3 cycles. Resumes at 0x3014 one edge after stall drops.
- Flush alone at PC 0x3020 → next cycle `ID_o_Valid`=0 and `ID_o_Instr`=0, while `IF_o_PC` advances to `IF_i_nPC`.
- Flush and stall together → IF/ID bubble and `IF_o_PC` held. The next load edge captures the held PC's instruction with Valid=1.
- `IF_i_nPC`=0x3000_1000 (branch target) → `IF_o_PC`=0x3000_1000 next cycle. Reset asserted while stalled → `IF_o_PC`=0x3000 and Valid=0 on that edge.
- With `FETCH_EXC_EN`:
  - nPC=0x3002 → `ID_o_ExcCode`=4, Instr=0, PC=0x3002.
  - nPC=0x7000 → ExcCode=4.
  - nPC=0x6FFC → ExcCode=0.
